// File: rtl/imm_movwide_encoder_if.sv
// Handshake bundle for the move-wide encoder: a request channel carrying
// the constant and destination register, and an instruction output channel.
interface imm_movwide_encoder_if;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_value;
    logic [4:0]  req_rd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_last;
    logic [1:0]  out_index;

    modport master (
        output req_valid, req_value, req_rd, out_ready,
        input  req_ready, out_valid, out_instr, out_last, out_index
    );

    modport slave (
        input  req_valid, req_value, req_rd, out_ready,
        output req_ready, out_valid, out_instr, out_last, out_index
    );
endinterface

// File: rtl/imm_movwide_encoder.sv
// Turns a 64-bit constant into a MOVZ/MOVN + MOVK sequence, one 32-bit
// instruction per output handshake, last flag on the final word.
module imm_movwide_encoder #(
    parameter bit ALLOW_MOVN = 1'b0
) (
    input logic                  CLK,
    input logic                  resetl,
    imm_movwide_encoder_if.slave bus
);

    typedef enum logic {IDLE, EMIT} state_t;

    localparam logic [31:0] MOVZ = 32'hD280_0000;
    localparam logic [31:0] MOVK = 32'hF280_0000;
    localparam logic [31:0] MOVN = 32'h9280_0000;

    function automatic logic [1:0] low_idx(input logic [3:0] m);
        logic [1:0] r;
        r = 2'd0;
        if (m[0])      r = 2'd0;
        else if (m[1]) r = 2'd1;
        else if (m[2]) r = 2'd2;
        else if (m[3]) r = 2'd3;
        return r;
    endfunction

    function automatic logic [15:0] half(input logic [63:0] v,
                                         input logic [1:0]  h);
        return v[{h, 4'b0000} +: 16];
    endfunction

    function automatic logic [31:0] enc(input logic [31:0] base,
                                        input logic [1:0]  hw,
                                        input logic [15:0] imm,
                                        input logic [4:0]  rd);
        return base | {9'd0, hw, 21'd0} | {11'd0, imm, 5'd0} | {27'd0, rd};
    endfunction

    state_t      state, state_n;
    logic [63:0] val_r, val_n;
    logic [4:0]  rd_r, rd_n;
    logic [3:0]  rest_r, rest_n;
    logic        valid_r, valid_n;
    logic [31:0] instr_r, instr_n;
    logic        last_r, last_n;
    logic [1:0]  index_r, index_n;

    logic [2:0]  z_cnt, f_cnt;
    logic        use_movn;
    logic [15:0] fill;
    logic [3:0]  cap_mask, cap_rest;
    logic [1:0]  cap_h;
    logic [15:0] cap_imm;
    logic [1:0]  nxt_h;
    logic [3:0]  nxt_rest;

    assign bus.req_ready = (state == IDLE);
    assign bus.out_valid = valid_r;
    assign bus.out_instr = instr_r;
    assign bus.out_last  = last_r;
    assign bus.out_index = index_r;

    // Mode choice and first word for the incoming request.
    always_comb begin
        z_cnt    = 3'd0;
        f_cnt    = 3'd0;
        cap_mask = 4'd0;
        for (int h = 0; h < 4; h++) begin
            if (bus.req_value[h*16 +: 16] == 16'h0000) z_cnt = z_cnt + 3'd1;
            if (bus.req_value[h*16 +: 16] == 16'hFFFF) f_cnt = f_cnt + 3'd1;
        end
        use_movn = ALLOW_MOVN && (f_cnt > z_cnt);
        fill     = use_movn ? 16'hFFFF : 16'h0000;
        for (int h = 0; h < 4; h++)
            cap_mask[h] = (bus.req_value[h*16 +: 16] != fill);
        // An all-fill constant leaves the mask empty; hw0 then holds fill,
        // so the imm below collapses to zero in both modes.
        cap_h    = low_idx(cap_mask);
        cap_imm  = half(bus.req_value, cap_h);
        if (use_movn) cap_imm = ~cap_imm;
        cap_rest = cap_mask & ~(4'b0001 << cap_h);
    end

    // Next MOVK from the halfwords still pending after the current word.
    always_comb begin
        nxt_h    = low_idx(rest_r);
        nxt_rest = rest_r & ~(4'b0001 << nxt_h);
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_n = state;
        val_n   = val_r;
        rd_n    = rd_r;
        rest_n  = rest_r;
        valid_n = valid_r;
        instr_n = instr_r;
        last_n  = last_r;
        index_n = index_r;
        unique case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    state_n = EMIT;
                    val_n   = bus.req_value;
                    rd_n    = bus.req_rd;
                    rest_n  = cap_rest;
                    valid_n = 1'b1;
                    instr_n = enc(use_movn ? MOVN : MOVZ, cap_h, cap_imm,
                                  bus.req_rd);
                    last_n  = (cap_rest == 4'd0);
                    index_n = 2'd0;
                end
            end
            EMIT: begin
                if (bus.out_ready) begin
                    if (last_r) begin
                        state_n = IDLE;
                        valid_n = 1'b0;
                    end else begin
                        rest_n  = nxt_rest;
                        instr_n = enc(MOVK, nxt_h, half(val_r, nxt_h), rd_r);
                        last_n  = (nxt_rest == 4'd0);
                        index_n = index_r + 2'd1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State and output registers; reset aborts any sequence in flight.
    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            state   <= IDLE;
            val_r   <= '0;
            rd_r    <= '0;
            rest_r  <= '0;
            valid_r <= 1'b0;
            instr_r <= '0;
            last_r  <= 1'b0;
            index_r <= '0;
        end else begin
            state   <= state_n;
            val_r   <= val_n;
            rd_r    <= rd_n;
            rest_r  <= rest_n;
            valid_r <= valid_n;
            instr_r <= instr_n;
            last_r  <= last_n;
            index_r <= index_n;
        end
    end

endmodule

// File: tb/tb_imm_movwide_encoder.sv
// Directed bench for imm_movwide_encoder: one DUT per ALLOW_MOVN setting,
// each scenario task checks its own hand-computed instruction words.
module tb_imm_movwide_encoder;

    logic CLK = 1'b0;
    logic resetl = 1'b0;
    always #5 CLK = ~CLK;

    imm_movwide_encoder_if b0 ();
    imm_movwide_encoder_if b1 ();

    imm_movwide_encoder #(.ALLOW_MOVN(1'b0)) u_z (
        .CLK(CLK), .resetl(resetl), .bus(b0.slave)
    );
    imm_movwide_encoder #(.ALLOW_MOVN(1'b1)) u_n (
        .CLK(CLK), .resetl(resetl), .bus(b1.slave)
    );

    int checks = 0;
    int errors = 0;

    logic        sel = 1'b0;
    logic        o_valid, o_last, o_rdy;
    logic [31:0] o_instr;
    logic [1:0]  o_index;
    assign o_valid = sel ? b1.out_valid : b0.out_valid;
    assign o_instr = sel ? b1.out_instr : b0.out_instr;
    assign o_last  = sel ? b1.out_last  : b0.out_last;
    assign o_index = sel ? b1.out_index : b0.out_index;
    assign o_rdy   = sel ? b1.req_ready : b0.req_ready;

    logic [31:0] got_instr [4];
    logic        got_last  [4];
    logic [1:0]  got_idx   [4];
    int          got_n;
    logic        lat;
    logic        tmo;

    task automatic drive_req(input logic v, input logic [63:0] val,
                             input logic [4:0] rd);
        if (sel) begin
            b1.req_valid = v; b1.req_value = val; b1.req_rd = rd;
        end else begin
            b0.req_valid = v; b0.req_value = val; b0.req_rd = rd;
        end
    endtask

    task automatic set_ready(input logic r);
        if (sel) b1.out_ready = r;
        else     b0.out_ready = r;
    endtask

    // Issue one request with out_ready held high and gather the words.
    task automatic run_req(input logic [63:0] val, input logic [4:0] rd);
        got_n = 0;
        tmo   = 1'b1;
        drive_req(1'b1, val, rd);
        set_ready(1'b1);
        @(posedge CLK); #1;
        drive_req(1'b0, 64'd0, 5'd0);
        lat = o_valid;
        for (int k = 0; k < 8; k++) begin
            if (o_valid && got_n < 4) begin
                got_instr[got_n] = o_instr;
                got_last[got_n]  = o_last;
                got_idx[got_n]   = o_index;
                got_n++;
            end
            @(posedge CLK); #1;
            if (got_n > 0 && got_last[got_n-1]) begin
                tmo = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset;
        b0.req_valid = 0; b0.req_value = '0; b0.req_rd = '0; b0.out_ready = 0;
        b1.req_valid = 0; b1.req_value = '0; b1.req_rd = '0; b1.out_ready = 0;
        resetl = 1'b0;
        #12;
        checks++;
        if (b0.req_ready !== 1'b1 || b0.out_valid !== 1'b0 ||
            b0.out_instr !== 32'd0 || b0.out_last !== 1'b0 ||
            b0.out_index !== 2'd0) begin
            errors++;
            $display("FAIL reset_state rdy=%b vld=%b ins=%h last=%b idx=%0d exp 1 0 0 0 0",
                     b0.req_ready, b0.out_valid, b0.out_instr,
                     b0.out_last, b0.out_index);
        end
        @(negedge CLK);
        resetl = 1'b1;
        @(posedge CLK); #1;
    endtask

    task automatic test_zero;
        sel = 1'b0;
        run_req(64'd0, 5'd3);
        checks++;
        if (tmo !== 1'b0 || got_n !== 1) begin
            errors++;
            $display("FAIL zero_count got %0d tmo=%b exp 1", got_n, tmo);
        end
        checks++;
        if (lat !== 1'b1) begin
            errors++;
            $display("FAIL zero_latency got %b exp 1", lat);
        end
        checks++;
        if (got_instr[0] !== 32'hD280_0003 || got_last[0] !== 1'b1 ||
            got_idx[0] !== 2'd0) begin
            errors++;
            $display("FAIL zero_word got %h/%b/%0d exp d2800003/1/0",
                     got_instr[0], got_last[0], got_idx[0]);
        end
        checks++;
        if (o_valid !== 1'b0 || o_rdy !== 1'b1) begin
            errors++;
            $display("FAIL zero_idle got vld=%b rdy=%b exp 0 1", o_valid, o_rdy);
        end
    endtask

    task automatic test_two_words;
        sel = 1'b0;
        run_req(64'h0000_1234_0000_5678, 5'd1);
        checks++;
        if (tmo !== 1'b0 || got_n !== 2) begin
            errors++;
            $display("FAIL two_count got %0d tmo=%b exp 2", got_n, tmo);
        end
        checks++;
        if (got_instr[0] !== 32'hD28A_CF01 || got_last[0] !== 1'b0 ||
            got_idx[0] !== 2'd0) begin
            errors++;
            $display("FAIL two_w0 got %h/%b/%0d exp d28acf01/0/0",
                     got_instr[0], got_last[0], got_idx[0]);
        end
        checks++;
        if (got_instr[1] !== 32'hF2C2_4681 || got_last[1] !== 1'b1 ||
            got_idx[1] !== 2'd1) begin
            errors++;
            $display("FAIL two_w1 got %h/%b/%0d exp f2c24681/1/1",
                     got_instr[1], got_last[1], got_idx[1]);
        end
    endtask

    task automatic test_four_words;
        logic [31:0] e [4];
        e[0] = 32'hD288_889F;
        e[1] = 32'hF2A6_667F;
        e[2] = 32'hF2C4_445F;
        e[3] = 32'hF2E2_223F;
        sel = 1'b0;
        run_req(64'h1111_2222_3333_4444, 5'd31);
        checks++;
        if (tmo !== 1'b0 || got_n !== 4) begin
            errors++;
            $display("FAIL four_count got %0d tmo=%b exp 4", got_n, tmo);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (got_instr[i] !== e[i] || got_last[i] !== (i == 3) ||
                got_idx[i] !== 2'(i)) begin
                errors++;
                $display("FAIL four_w%0d got %h/%b/%0d exp %h/%b/%0d", i,
                         got_instr[i], got_last[i], got_idx[i],
                         e[i], (i == 3), i);
            end
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] e [4];
        e[0] = 32'hD288_889F;
        e[1] = 32'hF2A6_667F;
        e[2] = 32'hF2C4_445F;
        e[3] = 32'hF2E2_223F;
        sel = 1'b0;
        set_ready(1'b0);
        drive_req(1'b1, 64'h1111_2222_3333_4444, 5'd31);
        @(posedge CLK); #1;
        // A second request while busy must be ignored.
        drive_req(1'b1, 64'hFFFF_0000_ABCD_0000, 5'd7);
        checks++;
        if (o_valid !== 1'b1 || o_instr !== e[0] || o_rdy !== 1'b0) begin
            errors++;
            $display("FAIL bp_w0 got vld=%b %h rdy=%b exp 1 %h 0",
                     o_valid, o_instr, o_rdy, e[0]);
        end
        set_ready(1'b1);
        @(posedge CLK); #1;
        set_ready(1'b0);
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (o_valid !== 1'b1 || o_instr !== e[1] || o_last !== 1'b0 ||
                o_index !== 2'd1) begin
                errors++;
                $display("FAIL bp_hold%0d got %b %h %b %0d exp 1 %h 0 1", c,
                         o_valid, o_instr, o_last, o_index, e[1]);
            end
            @(posedge CLK); #1;
        end
        drive_req(1'b0, 64'd0, 5'd0);
        set_ready(1'b1);
        for (int i = 1; i < 4; i++) begin
            checks++;
            if (o_valid !== 1'b1 || o_instr !== e[i] || o_last !== (i == 3)) begin
                errors++;
                $display("FAIL bp_w%0d got %b %h %b exp 1 %h %b", i,
                         o_valid, o_instr, o_last, e[i], (i == 3));
            end
            @(posedge CLK); #1;
        end
        checks++;
        if (o_valid !== 1'b0 || o_rdy !== 1'b1) begin
            errors++;
            $display("FAIL bp_idle got vld=%b rdy=%b exp 0 1", o_valid, o_rdy);
        end
    endtask

    task automatic test_movn;
        sel = 1'b1;
        run_req(64'hFFFF_FFFF_FFFF_1234, 5'd0);
        checks++;
        if (tmo !== 1'b0 || got_n !== 1 || got_instr[0] !== 32'h929D_B960 ||
            got_last[0] !== 1'b1) begin
            errors++;
            $display("FAIL movn_single got n=%0d %h/%b exp 1 929db960/1",
                     got_n, got_instr[0], got_last[0]);
        end
        run_req(64'hFFFF_FFFF_FFFF_FFFF, 5'd9);
        checks++;
        if (tmo !== 1'b0 || got_n !== 1 || got_instr[0] !== 32'h9280_0009 ||
            got_last[0] !== 1'b1) begin
            errors++;
            $display("FAIL movn_allones got n=%0d %h/%b exp 1 92800009/1",
                     got_n, got_instr[0], got_last[0]);
        end
        // Two zero and two 0xFFFF halfwords tie, so MOVZ is kept.
        run_req(64'hFFFF_0000_FFFF_0000, 5'd2);
        checks++;
        if (tmo !== 1'b0 || got_n !== 2 || got_instr[0] !== 32'hD2BF_FFE2 ||
            got_instr[1] !== 32'hF2FF_FFE2) begin
            errors++;
            $display("FAIL movn_tie got n=%0d %h %h exp 2 d2bfffe2 f2ffffe2",
                     got_n, got_instr[0], got_instr[1]);
        end
        sel = 1'b0;
    endtask

    task automatic test_no_movn;
        logic [31:0] e [4];
        e[0] = 32'hD282_4680;
        e[1] = 32'hF2BF_FFE0;
        e[2] = 32'hF2DF_FFE0;
        e[3] = 32'hF2FF_FFE0;
        sel = 1'b0;
        run_req(64'hFFFF_FFFF_FFFF_1234, 5'd0);
        checks++;
        if (tmo !== 1'b0 || got_n !== 4) begin
            errors++;
            $display("FAIL nomovn_count got %0d tmo=%b exp 4", got_n, tmo);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (got_instr[i] !== e[i] || got_last[i] !== (i == 3)) begin
                errors++;
                $display("FAIL nomovn_w%0d got %h/%b exp %h/%b", i,
                         got_instr[i], got_last[i], e[i], (i == 3));
            end
        end
    endtask

    task automatic test_reset_mid;
        sel = 1'b0;
        set_ready(1'b1);
        drive_req(1'b1, 64'h1111_2222_3333_4444, 5'd31);
        @(posedge CLK); #1;
        drive_req(1'b0, 64'd0, 5'd0);
        @(posedge CLK); #1;
        checks++;
        if (o_valid !== 1'b1 || o_index !== 2'd1) begin
            errors++;
            $display("FAIL rst_pre got vld=%b idx=%0d exp 1 1", o_valid, o_index);
        end
        #2;
        resetl = 1'b0;
        #1;
        checks++;
        if (o_valid !== 1'b0 || o_rdy !== 1'b1 || o_index !== 2'd0) begin
            errors++;
            $display("FAIL rst_async got vld=%b rdy=%b idx=%0d exp 0 1 0",
                     o_valid, o_rdy, o_index);
        end
        @(negedge CLK);
        resetl = 1'b1;
        @(posedge CLK); #1;
        run_req(64'h0000_1234_0000_5678, 5'd1);
        checks++;
        if (tmo !== 1'b0 || got_n !== 2 || got_instr[0] !== 32'hD28A_CF01 ||
            got_instr[1] !== 32'hF2C2_4681 || got_idx[0] !== 2'd0) begin
            errors++;
            $display("FAIL rst_after got n=%0d %h %h idx0=%0d exp 2 d28acf01 f2c24681 0",
                     got_n, got_instr[0], got_instr[1], got_idx[0]);
        end
    endtask

    initial begin
        test_reset();
        test_zero();
        test_two_words();
        test_four_words();
        test_backpressure();
        test_movn();
        test_no_movn();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
